// File: rtl/tqvp_bus_pkg.sv
// Shared types for the TinyQV bus initiator: size encodings, idle strobe value,
// FSM state enum and the queued command record.
package tqvp_bus_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // Strobe value meaning "no access" on data_write_n / data_read_n
    localparam logic [1:0] BUS_IDLE = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StResp
    } state_e;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    // Zero-extend read data to the access size
    function automatic logic [31:0] mask_rdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] res;
        res = data;
        if (size == SIZE_BYTE) begin
            res = {24'b0, data[7:0]};
        end else if (size == SIZE_HALF) begin
            res = {16'b0, data[15:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/tqvp_cmd_fifo.sv
// Synchronous command FIFO. Full/empty come straight from the registered
// pointers; pushes while full and pops while empty are ignored.
module tqvp_cmd_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [Width-1:0] mem [Depth];
    logic [AW:0]      wptr_q, rptr_q;
    logic             push_en, pop_en;

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // Pointers carry one extra wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_en) wptr_q <= wptr_q + PtrOne;
            if (pop_en)  rptr_q <= rptr_q + PtrOne;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push_en) mem[wptr_q[AW-1:0]] <= push_data;
    end

    assign head  = mem[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/tqvp_bus_initiator.sv
// TinyQV peripheral bus initiator: pops queued commands and replays them on the
// peripheral register bus, returning one response per read.
// Optional feature macro: TQVP_BUS_WRITE_ACK_EN (writes also produce responses).
module tqvp_bus_initiator
    import tqvp_bus_pkg::*;
#(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [5:0]  bus_address,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_write_n,
    output logic [1:0]  bus_read_n,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        busy
);

`ifdef TQVP_BUS_WRITE_ACK_EN
    localparam bit WriteAck = 1'b1;
`else
    localparam bit WriteAck = 1'b0;
`endif

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    cmd_t        cmd_in, fifo_head;
    logic        fifo_full, fifo_empty, fifo_pop;

    state_e      state_q, state_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [5:0]  bus_address_q, bus_address_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]  bus_write_n_q, bus_write_n_d;
    logic [1:0]  bus_read_n_q, bus_read_n_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    assign cmd_in = '{write: cmd_write, size: cmd_size, addr: cmd_addr, wdata: cmd_wdata};

    tqvp_cmd_fifo #(
        .Depth (CMD_DEPTH),
        .Width ($bits(cmd_t))
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state logic: dispatch from IDLE, run the strobe, hold the response
    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        bus_address_d = bus_address_q;
        bus_wdata_d   = bus_wdata_q;
        bus_write_n_d = bus_write_n_q;
        bus_read_n_d  = bus_read_n_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        fifo_pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (fifo_head.size == SIZE_ILLEGAL) begin
                        // No bus cycle; illegal writes vanish unless writes are acked
                        if (WriteAck || !fifo_head.write) begin
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = '0;
                            rsp_err_d   = 1'b1;
                            state_d     = StResp;
                        end
                    end else if (fifo_head.write) begin
                        bus_address_d = fifo_head.addr;
                        bus_wdata_d   = fifo_head.wdata;
                        bus_write_n_d = fifo_head.size;
                        state_d       = StWrite;
                    end else begin
                        bus_address_d = fifo_head.addr;
                        bus_read_n_d  = fifo_head.size;
                        tmo_d         = '0;
                        state_d       = StRead;
                    end
                end
            end
            StWrite: begin
                bus_write_n_d = BUS_IDLE;
                if (WriteAck) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = StResp;
                end else begin
                    state_d = StIdle;
                end
            end
            StRead: begin
                // A ready in the final allowed cycle still wins over the timeout
                if (bus_ready) begin
                    bus_read_n_d = BUS_IDLE;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = mask_rdata(bus_read_n_q, bus_rdata);
                    rsp_err_d    = 1'b0;
                    state_d      = StResp;
                end else if (tmo_q == TimeoutLast) begin
                    bus_read_n_d = BUS_IDLE;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = '0;
                    rsp_err_d    = 1'b1;
                    state_d      = StResp;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered bus/response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            tmo_q         <= '0;
            bus_address_q <= '0;
            bus_wdata_q   <= '0;
            bus_write_n_q <= BUS_IDLE;
            bus_read_n_q  <= BUS_IDLE;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            bus_address_q <= bus_address_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_write_n_q <= bus_write_n_d;
            bus_read_n_q  <= bus_read_n_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign cmd_ready   = !fifo_full;
    assign busy        = !fifo_empty || (state_q != StIdle);
    assign bus_address = bus_address_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_write_n = bus_write_n_q;
    assign bus_read_n  = bus_read_n_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Bench for tqvp_bus_initiator: directed protocol checks plus randomized command
// streams scored against a transaction-level model of the expected bus traffic
// and responses. Honours TQVP_BUS_WRITE_ACK_EN when building expectations.
module tb_tqvp_bus_initiator;

`ifdef TQVP_BUS_WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif
    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [1:0]  cmd_size = 2'd0;
    logic [5:0]  cmd_addr = 6'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_ready = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_ready = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata, bus_wdata;
    logic [5:0]  bus_address;
    logic [1:0]  bus_write_n, bus_read_n;

    tqvp_bus_initiator #(
        .CMD_DEPTH      (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_size    (cmd_size),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .bus_address (bus_address),
        .bus_wdata   (bus_wdata),
        .bus_write_n (bus_write_n),
        .bus_read_n  (bus_read_n),
        .bus_rdata   (bus_rdata),
        .bus_ready   (bus_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        write;
        bit [1:0]  size;
        bit [5:0]  addr;
        bit [31:0] wdata;
        int        start;
    } txn_t;

    typedef struct {
        bit       from_bus;
        bit       err;
        bit [1:0] size;
    } exp_t;

    int          total = 0, bad = 0;
    txn_t        iss_q[$], seen_q[$];
    exp_t        exp_q[$];
    int          delay_q[$];
    logic [31:0] ready_vals[$];
    int          pend_delay = 0;
    bit          auto_rsp = 1'b0;
    bit          fixed_en = 1'b0;
    logic [31:0] fixed_val = 32'd0;
    int          cyc = 0, rd_len = 0, wr_len = 0, cur_delay = 0;
    int          last_rd_len = 0, long_wr = 0;
    int          dly_tab[7] = '{0, 1, 2, 3, 14, 15, 20};

    // Responder and bus monitor, evaluated just after each active edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus_read_n != 2'b11) begin
            if (rd_len == 0) begin
                cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                seen_q.push_back('{write: 1'b0, size: bus_read_n, addr: bus_address,
                                   wdata: 32'd0, start: cyc});
            end
            rd_len++;
            bus_rdata = fixed_en ? fixed_val : $urandom;
            bus_ready = (rd_len > cur_delay);
            if (bus_ready) ready_vals.push_back(bus_rdata);
        end else begin
            if (rd_len != 0) last_rd_len = rd_len;
            rd_len    = 0;
            bus_ready = 1'b0;
            bus_rdata = $urandom;
        end
        if (bus_write_n != 2'b11) begin
            if (wr_len == 0)
                seen_q.push_back('{write: 1'b1, size: bus_write_n, addr: bus_address,
                                   wdata: bus_wdata, start: cyc});
            wr_len++;
            if (wr_len > 1) long_wr++;
        end else begin
            wr_len = 0;
        end
    end

    function automatic logic [31:0] sized(input logic [31:0] v, input logic [1:0] sz);
        if (sz == 2'd0) return v % 32'd256;
        if (sz == 2'd1) return v % 32'd65536;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        total++;
        bad++;
        $error("FAIL %s: observed=bound expired expected=event", tag);
    endtask

    // Record a command accepted on the coming edge in the model
    task automatic accept();
        txn_t t;
        t = '{write: cmd_write, size: cmd_size, addr: cmd_addr, wdata: cmd_wdata, start: 0};
        if (cmd_size == 2'd3) begin
            if (!cmd_write || ACK) exp_q.push_back('{from_bus: 1'b0, err: 1'b1, size: cmd_size});
        end else begin
            iss_q.push_back(t);
            if (cmd_write) begin
                if (ACK) exp_q.push_back('{from_bus: 1'b0, err: 1'b0, size: cmd_size});
            end else begin
                delay_q.push_back(pend_delay);
                exp_q.push_back('{from_bus: (pend_delay < TMO), err: (pend_delay >= TMO),
                                  size: cmd_size});
            end
        end
    endtask

    task automatic check_rsp();
        exp_t        e;
        logic [31:0] want;
        if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            return;
        end
        e    = exp_q.pop_front();
        want = 32'd0;
        if (e.from_bus) begin
            if (ready_vals.size() == 0) bound_fail("rsp_without_ready_cycle");
            else want = sized(ready_vals.pop_front(), e.size);
        end
        chk("rsp_rdata", rsp_rdata, want);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
    endtask

    // One clock: score handshakes completing on this edge, then advance
    task automatic step();
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) check_rsp();
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) accept();
        @(negedge clk);
        if (auto_rsp) rsp_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic push(input bit w, input bit [1:0] sz, input bit [5:0] a,
                        input bit [31:0] d, input int dly);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_size  = sz;
        cmd_addr  = a;
        cmd_wdata = d;
        pend_delay = dly;
        while (cmd_ready !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) bound_fail("push_wait");
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || rsp_valid !== 1'b0 || exp_q.size() != 0) && n < 600) begin
            step();
            n++;
        end
        if (n >= 600) bound_fail("wait_idle");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_write_n", 32'(bus_write_n), 32'd3);
        chk("reset_read_n", 32'(bus_read_n), 32'd3);
        chk("reset_address", 32'(bus_address), 32'd0);
        chk("reset_wdata", bus_wdata, 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Word write: one-cycle strobe starting the edge after acceptance
        push(1'b1, 2'd2, 6'h18, 32'h0000_01FF, 0);
        chk("wr_strobe_k", 32'(bus_write_n), 32'd3);
        step();
        chk("wr_strobe_k1", 32'(bus_write_n), 32'd2);
        chk("wr_address", 32'(bus_address), 32'h18);
        chk("wr_wdata", bus_wdata, 32'h1FF);
        step();
        chk("wr_strobe_k2", 32'(bus_write_n), 32'd3);
        chk("wr_ack_valid", 32'(rsp_valid), 32'(ACK));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Byte read, ready immediate: response two edges after acceptance
        fixed_en  = 1'b1;
        fixed_val = 32'hDEAD_BEEF;
        push(1'b0, 2'd0, 6'h04, 32'd0, 0);
        chk("rd_strobe_k", 32'(bus_read_n), 32'd3);
        step();
        chk("rd_strobe_k1", 32'(bus_read_n), 32'd0);
        chk("rd_address", 32'(bus_address), 32'h04);
        chk("rd_rsp_early", 32'(rsp_valid), 32'd0);
        step();
        chk("rd_rsp_k2", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_data_k2", rsp_rdata, 32'h0000_00EF);
        chk("rd_strobe_k2", 32'(bus_read_n), 32'd3);
        rsp_ready = 1'b1;
        step();
        fixed_en = 1'b0;

        // Half read with ready three cycles late
        push(1'b0, 2'd1, 6'h08, 32'd0, 3);
        wait_idle();
        chk("half_strobe_len", 32'(last_rd_len), 32'd4);

        // Ready stuck low: timeout after exactly TMO strobe cycles
        push(1'b0, 2'd2, 6'h0C, 32'd0, 1000);
        wait_idle();
        chk("timeout_strobe_len", 32'(last_rd_len), 32'(TMO));

        // Backpressure: FIFO fills while the first response is held
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 2'($urandom_range(0, 2)), 6'($urandom_range(0, 63)), 32'd0,
                 (i == 0) ? 0 : $urandom_range(0, 2));
            if (i == 3) chk("fifo_three_ready", 32'(cmd_ready), 32'd1);
        end
        chk("fifo_full_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, sized(ready_vals[0], exp_q[0].size));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            step();
        end
        auto_rsp = 1'b1;
        push(1'b0, 2'd2, 6'h3F, 32'd0, 1);
        wait_idle();
        auto_rsp = 1'b0;

        // Strobe spacing for back-to-back writes and reads
        rsp_ready = 1'b1;
        push(1'b1, 2'd2, 6'h20, $urandom, 0);
        push(1'b1, 2'd0, 6'h21, $urandom, 0);
        wait_idle();
        chk("wr_spacing", 32'(seen_q[$].start - seen_q[$-1].start), ACK ? 32'd3 : 32'd2);
        push(1'b0, 2'd2, 6'h22, 32'd0, 0);
        push(1'b0, 2'd1, 6'h23, 32'd0, 0);
        wait_idle();
        chk("rd_spacing", 32'(seen_q[$].start - seen_q[$-1].start), 32'd3);

        // Random mix of reads, writes, illegal sizes and ready delays
        auto_rsp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                 6'($urandom_range(0, 63)), $urandom, dly_tab[$urandom_range(0, 6)]);
            if ($urandom_range(0, 3) == 0) step();
        end
        wait_idle();
        auto_rsp = 1'b0;

        // Every legal command appears on the bus once, in order, with its fields
        chk("bus_txn_count", 32'(seen_q.size()), 32'(iss_q.size()));
        for (int i = 0; i < seen_q.size() && i < iss_q.size(); i++) begin
            chk("bus_txn_write", 32'(seen_q[i].write), 32'(iss_q[i].write));
            chk("bus_txn_size", 32'(seen_q[i].size), 32'(iss_q[i].size));
            chk("bus_txn_addr", 32'(seen_q[i].addr), 32'(iss_q[i].addr));
            if (iss_q[i].write) chk("bus_txn_wdata", seen_q[i].wdata, iss_q[i].wdata);
        end
        chk("write_strobe_one_cycle", 32'(long_wr), 32'd0);

        // Reset during the second cycle of a stalled read with more queued
        rsp_ready = 1'b0;
        push(1'b0, 2'd2, 6'h30, 32'd0, 1000);
        push(1'b0, 2'd1, 6'h31, 32'd0, 0);
        push(1'b1, 2'd2, 6'h32, 32'h1234, 0);
        chk("rst_pre_strobe", 32'(bus_read_n), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_read_n", 32'(bus_read_n), 32'd3);
        chk("rst_write_n", 32'(bus_write_n), 32'd3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        exp_q.delete();
        delay_q.delete();
        ready_vals.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_read_n", 32'(bus_read_n), 32'd3);
        chk("post_rst_write_n", 32'(bus_write_n), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
